// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT read mode.
module sync_fifo_flags #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       w_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfC    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeC    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] OneC   = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Flags come straight from the registered count.
  always_comb begin
    full         = (count_q == DepthC);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfC);
    almost_empty = (count_q <= AeC);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Accept decisions and next-state for pointers, count and sticky flags.
  always_comb begin
    wr_acc      = w_en && !full;
    rd_acc      = r_en && !empty;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q || (w_en && full);
    underflow_d = underflow_q || (r_en && empty);
    if (wr_acc) wptr_d = wptr_q + OneC;
    if (rd_acc) rptr_d = rptr_q + OneC;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + OneC;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - OneC;
    end
  end

  // State register; rst beats flush, both clear everything but memory.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[wptr_q[AW-1:0]] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented combinationally while the FIFO holds data.
    always_comb begin
      data_out = empty ? '0 : mem[rptr_q[AW-1:0]];
    end
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q;

    // Registered read: update only on an accepted read, otherwise hold.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        rdata_q <= '0;
      end else if (rd_acc) begin
        rdata_q <= mem[rptr_q[AW-1:0]];
      end
    end

    always_comb begin
      data_out = rdata_q;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: directed vector table, hand-written
// corner sequences and randomized traffic checked against a queue-based model.
module tb_sync_fifo_flags;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, flush, w_en, r_en;
  logic [WIDTH-1:0] data_in;

  logic [WIDTH-1:0] dout0, dout1;
  logic             full0, empty0, af0, ae0, ov0, uf0;
  logic             full1, empty1, af1, ae1, ov1, uf1;
  logic [3:0]       cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_q[$];
  logic             m_ov, m_uf;
  logic [WIDTH-1:0] m_dout0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(uf0)
  );

  sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(uf1)
  );

  typedef struct {
    logic       rst, flush, w;
    logic [7:0] d;
    logic       r;
    logic [3:0] cnt;
    logic       full, empty, af, ae, ov, uf;
    logic [7:0] d0, d1;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs over one rising edge, advance the model, settle for sampling.
  task automatic tick(input logic i_rst, input logic i_fl, input logic i_w,
                      input logic [7:0] i_d, input logic i_r);
    bit was_full, was_empty;
    rst = i_rst; flush = i_fl; w_en = i_w; data_in = i_d; r_en = i_r;
    @(posedge clk);
    if (i_rst || i_fl) begin
      m_q.delete();
      m_ov = 1'b0; m_uf = 1'b0; m_dout0 = '0;
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      if (i_w && was_full) m_ov = 1'b1;
      if (i_r && was_empty) m_uf = 1'b1;
      if (i_r && !was_empty) m_dout0 = m_q.pop_front();
      if (i_w && !was_full) m_q.push_back(i_d);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = m_q.size();
    check({tag, ".count"}, 32'(cnt0), 32'(sz));
    check({tag, ".count_fwft"}, 32'(cnt1), 32'(sz));
    check({tag, ".full"}, 32'(full0), 32'(sz == DEPTH));
    check({tag, ".empty"}, 32'(empty0), 32'(sz == 0));
    check({tag, ".almost_full"}, 32'(af0), 32'(sz >= 6));
    check({tag, ".almost_empty"}, 32'(ae0), 32'(sz <= 2));
    check({tag, ".overflow"}, 32'(ov0), 32'(m_ov));
    check({tag, ".underflow"}, 32'(uf0), 32'(m_uf));
    check({tag, ".data_out"}, 32'(dout0), 32'(m_dout0));
    check({tag, ".data_out_fwft"}, 32'(dout1), (sz == 0) ? 32'h0 : 32'(m_q[0]));
  endtask

  initial begin
    // rst fl w  d     r  cnt full emp af ae ov uf d0     d1
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00};
    tbl[1]  = '{0, 0, 1, 8'h01, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h01};
    tbl[2]  = '{0, 0, 1, 8'h02, 0, 2, 0, 0, 0, 1, 0, 0, 8'h00, 8'h01};
    tbl[3]  = '{0, 0, 1, 8'h03, 0, 3, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01};
    tbl[4]  = '{0, 0, 1, 8'h04, 0, 4, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01};
    tbl[5]  = '{0, 0, 1, 8'h05, 0, 5, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01};
    tbl[6]  = '{0, 0, 1, 8'h06, 0, 6, 0, 0, 1, 0, 0, 0, 8'h00, 8'h01};
    tbl[7]  = '{0, 0, 1, 8'h07, 0, 7, 0, 0, 1, 0, 0, 0, 8'h00, 8'h01};
    tbl[8]  = '{0, 0, 1, 8'h08, 0, 8, 1, 0, 1, 0, 0, 0, 8'h00, 8'h01};
    tbl[9]  = '{0, 0, 1, 8'hAA, 0, 8, 1, 0, 1, 0, 1, 0, 8'h00, 8'h01};
    tbl[10] = '{0, 0, 0, 8'h00, 1, 7, 0, 0, 1, 0, 1, 0, 8'h01, 8'h02};
    tbl[11] = '{0, 0, 0, 8'h00, 0, 7, 0, 0, 1, 0, 1, 0, 8'h01, 8'h02};
    tbl[12] = '{0, 0, 0, 8'h00, 1, 6, 0, 0, 1, 0, 1, 0, 8'h02, 8'h03};
    tbl[13] = '{0, 0, 0, 8'h00, 1, 5, 0, 0, 0, 0, 1, 0, 8'h03, 8'h04};
    tbl[14] = '{0, 0, 0, 8'h00, 1, 4, 0, 0, 0, 0, 1, 0, 8'h04, 8'h05};
    tbl[15] = '{0, 0, 0, 8'h00, 1, 3, 0, 0, 0, 0, 1, 0, 8'h05, 8'h06};
    tbl[16] = '{0, 0, 0, 8'h00, 1, 2, 0, 0, 0, 1, 1, 0, 8'h06, 8'h07};
    tbl[17] = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 0, 8'h07, 8'h08};
    tbl[18] = '{0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 0, 8'h08, 8'h00};
    tbl[19] = '{0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 1, 8'h08, 8'h00};
    tbl[20] = '{0, 0, 1, 8'h5C, 0, 1, 0, 0, 0, 1, 1, 1, 8'h08, 8'h5C};
    tbl[21] = '{0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 1, 8'h5C, 8'h00};

    rst = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    m_ov = 1'b0; m_uf = 1'b0; m_dout0 = '0;
    repeat (2) @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 22; i++) begin
      tick(tbl[i].rst, tbl[i].flush, tbl[i].w, tbl[i].d, tbl[i].r);
      check($sformatf("vec%0d.count", i), 32'(cnt0), 32'(tbl[i].cnt));
      check($sformatf("vec%0d.full", i), 32'(full0), 32'(tbl[i].full));
      check($sformatf("vec%0d.empty", i), 32'(empty0), 32'(tbl[i].empty));
      check($sformatf("vec%0d.almost_full", i), 32'(af0), 32'(tbl[i].af));
      check($sformatf("vec%0d.almost_empty", i), 32'(ae0), 32'(tbl[i].ae));
      check($sformatf("vec%0d.overflow", i), 32'(ov0), 32'(tbl[i].ov));
      check($sformatf("vec%0d.underflow", i), 32'(uf0), 32'(tbl[i].uf));
      check($sformatf("vec%0d.data_out", i), 32'(dout0), 32'(tbl[i].d0));
      check($sformatf("vec%0d.data_out_fwft", i), 32'(dout1), 32'(tbl[i].d1));
    end

    // Steady simultaneous read/write at count 4 across pointer wraps.
    tick(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 1, 8'(8'h20 + i), 1);
      check($sformatf("rw%0d.count", i), 32'(cnt0), 32'd4);
      check($sformatf("rw%0d.flags", i), {28'h0, full0, empty0, af0, ae0}, 32'h0);
      check($sformatf("rw%0d.data_out", i), 32'(dout0),
            (i < 4) ? 32'(8'h10 + i) : 32'(8'h20 + i - 4));
    end

    // Flush with a concurrent write at count 5 and overflow set.
    tick(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 8'(8'h30 + i), 0);
    tick(0, 0, 1, 8'h99, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h00, 1);
    check("pre_flush.count", 32'(cnt0), 32'd5);
    check("pre_flush.overflow", 32'(ov0), 32'd1);
    check("pre_flush.data_out", 32'(dout0), 32'h32);
    tick(0, 1, 1, 8'h77, 0);
    check("flush.count", 32'(cnt0), 32'd0);
    check("flush.empty", 32'(empty0), 32'd1);
    check("flush.overflow", 32'(ov0), 32'd0);
    check("flush.data_out", 32'(dout0), 32'h0);
    check("flush.data_out_fwft", 32'(dout1), 32'h0);
    tick(0, 0, 0, 8'h00, 0);
    check("post_flush.count", 32'(cnt0), 32'd0);
    tick(0, 0, 1, 8'h41, 0);
    tick(0, 0, 0, 8'h00, 1);
    check("post_flush.data_out", 32'(dout0), 32'h41);
    check("post_flush.empty", 32'(empty0), 32'd1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      logic rr, ff, ww, rd;
      rr = ($urandom_range(0, 499) == 0);
      ff = ($urandom_range(0, 79) == 0);
      ww = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 65 : 35));
      rd = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 35 : 65));
      tick(rr, ff, ww, 8'($urandom), rd);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
